// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter
// Shares one picorv32 native memory port between the CPU (requester 0) and a
// secondary master (requester 1). One transaction at a time, round-robin on
// ties, with a watchdog that force-completes transfers the fabric never acks.
module picorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    output logic [7:0]  err_count
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } state_t;

    // Watchdog sizing: a zero timeout still needs a 1-bit counter to stay legal.
    localparam int unsigned      WD_RAW  = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam int unsigned      WD_W    = (WD_RAW < 32'd1) ? 32'd1 : WD_RAW;
    localparam logic             WD_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [WD_W-1:0]  WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 32'd1) : '0;
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(32'd1);

    state_t            r_state;
    logic              r_last;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [7:0]        r_err_count;

    logic              w_own_valid;
    logic              w_wd_expire;
    logic              w_done;
    logic              w_timeout;
    logic [31:0]       w_rdata;

    assign grant     = r_state;
    assign err_count = r_err_count;

    // Owner qualification, watchdog expiry and completion decode.
    always_comb begin
        w_own_valid = 1'b0;
        case (r_state)
            BUSY0:   w_own_valid = m0_mem_valid;
            BUSY1:   w_own_valid = m1_mem_valid;
            default: w_own_valid = 1'b0;
        endcase
        if (WD_EN && (r_state != IDLE) && (r_wd_cnt == WD_LAST)) begin
            w_wd_expire = 1'b1;
        end else begin
            w_wd_expire = 1'b0;
        end
        // A fabric ack coincident with expiry wins: it is a normal completion.
        w_done    = w_own_valid & (s_mem_ready | w_wd_expire);
        w_timeout = w_own_valid & w_wd_expire & ~s_mem_ready;
        w_rdata   = s_mem_ready ? s_mem_rdata : ERR_RDATA;
    end

    // Downstream mux and requester responses; everything is zero while idle.
    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_addr   = 32'h0000_0000;
        s_mem_wdata  = 32'h0000_0000;
        s_mem_wstrb  = 4'b0000;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = 32'h0000_0000;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = 32'h0000_0000;
        timeout_err  = w_timeout;
        case (r_state)
            BUSY0: begin
                s_mem_valid  = m0_mem_valid;
                s_mem_instr  = m0_mem_instr;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = w_done;
                m0_mem_rdata = w_rdata;
            end
            BUSY1: begin
                s_mem_valid  = m1_mem_valid;
                s_mem_instr  = m1_mem_instr;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = w_done;
                m1_mem_rdata = w_rdata;
            end
            default: begin
                timeout_err = 1'b0;
            end
        endcase
    end

    // Arbitration FSM with round-robin tie memory and watchdog counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_wd_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wd_cnt <= '0;
                    if (m0_mem_valid && m1_mem_valid) begin
                        if (r_last) begin
                            r_state <= BUSY0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= BUSY1;
                            r_last  <= 1'b1;
                        end
                    end else if (m0_mem_valid) begin
                        r_state <= BUSY0;
                    end else if (m1_mem_valid) begin
                        r_state <= BUSY1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY0, BUSY1: begin
                    // Leave after the ready pulse, or at once on a protocol abort.
                    if (!w_own_valid || w_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                    if (!s_mem_ready) begin
                        r_wd_cnt <= r_wd_cnt + WD_ONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_wd_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of forced completions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_count <= 8'd0;
        end else if (w_timeout && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench for picorv32_mem_arbiter: directed vector table, a few
// multi-cycle sequences and randomized traffic against a transaction-level model.
module tb_picorv32_mem_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_mem_valid, m0_mem_instr, m1_mem_valid, m1_mem_instr;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m1_mem_addr, m1_mem_wdata;
    logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
    logic        m0_mem_ready, m1_mem_ready;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic        s_mem_valid, s_mem_instr, s_mem_ready;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [3:0]  s_mem_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: owner is -1 when the port is free.
    int mdl_owner, mdl_last, mdl_wait, mdl_errs;
    bit mdl_ov, mdl_done, mdl_to;

    typedef struct {
        bit          m0v;
        bit          srdy;
        bit          e_sval;
        bit          e_m0rdy;
        logic [31:0] e_m0rd;
        logic [1:0]  e_gnt;
        bit          e_to;
        logic [7:0]  e_err;
    } vec_t;

    vec_t tbl[20];
    logic [1:0] gq[$];

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
        .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
        .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
        .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .grant(grant), .timeout_err(timeout_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit m0v, bit srdy, bit sv, bit rdy, logic [31:0] rd,
                                logic [1:0] g, bit to, logic [7:0] e);
        vec_t v;
        v.m0v = m0v; v.srdy = srdy; v.e_sval = sv; v.e_m0rdy = rdy; v.e_m0rd = rd;
        v.e_gnt = g; v.e_to = to; v.e_err = e;
        return v;
    endfunction

    task automatic model_reset();
        mdl_owner = -1; mdl_last = 1; mdl_wait = 0; mdl_errs = 0;
    endtask

    // Compare every output against what the transfer rules predict this cycle.
    task automatic model_check();
        bit xp;
        logic [31:0] rd;
        mdl_ov   = (mdl_owner == 0) ? m0_mem_valid : (mdl_owner == 1) ? m1_mem_valid : 1'b0;
        xp       = (TO != 0) && (mdl_owner >= 0) && (mdl_wait == TO - 1);
        mdl_done = mdl_ov && (s_mem_ready || xp);
        mdl_to   = mdl_ov && xp && !s_mem_ready;
        rd       = s_mem_ready ? s_mem_rdata : ERR;
        check("m0_ready", {31'd0, m0_mem_ready}, {31'd0, mdl_owner == 0 && mdl_done});
        check("m1_ready", {31'd0, m1_mem_ready}, {31'd0, mdl_owner == 1 && mdl_done});
        check("m0_rdata", m0_mem_rdata, (mdl_owner == 0) ? rd : 32'd0);
        check("m1_rdata", m1_mem_rdata, (mdl_owner == 1) ? rd : 32'd0);
        check("s_valid", {31'd0, s_mem_valid}, {31'd0, mdl_ov});
        check("s_instr", {31'd0, s_mem_instr}, {31'd0, (mdl_owner == 0) ? m0_mem_instr :
                                                       (mdl_owner == 1) ? m1_mem_instr : 1'b0});
        check("s_addr", s_mem_addr, (mdl_owner == 0) ? m0_mem_addr :
                                    (mdl_owner == 1) ? m1_mem_addr : 32'd0);
        check("s_wdata", s_mem_wdata, (mdl_owner == 0) ? m0_mem_wdata :
                                      (mdl_owner == 1) ? m1_mem_wdata : 32'd0);
        check("s_wstrb", {28'd0, s_mem_wstrb}, {28'd0, (mdl_owner == 0) ? m0_mem_wstrb :
                                                       (mdl_owner == 1) ? m1_mem_wstrb : 4'd0});
        check("grant", {30'd0, grant}, (mdl_owner == 0) ? 32'd1 : (mdl_owner == 1) ? 32'd2 : 32'd0);
        check("timeout_err", {31'd0, timeout_err}, {31'd0, mdl_to});
        check("err_count", {24'd0, err_count}, mdl_errs);
    endtask

    // Advance the model across one clock edge using the inputs held this cycle.
    task automatic model_update();
        if (mdl_owner < 0) begin
            if (m0_mem_valid && m1_mem_valid) begin
                mdl_owner = (mdl_last == 1) ? 0 : 1;
                mdl_last  = mdl_owner;
            end else if (m0_mem_valid) begin
                mdl_owner = 0;
            end else if (m1_mem_valid) begin
                mdl_owner = 1;
            end
            mdl_wait = 0;
        end else begin
            if (!mdl_ov || mdl_done) mdl_owner = -1;
            if (!s_mem_ready) mdl_wait++;
            if (mdl_to && mdl_errs < 255) mdl_errs++;
        end
    endtask

    // One cycle: check at the falling edge, step the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        m0_mem_valid = 1'b1; m1_mem_valid = 1'b1; m0_mem_instr = 1'b1; m1_mem_instr = 1'b1;
        m0_mem_addr = 32'h100; m0_mem_wdata = 32'd0; m0_mem_wstrb = 4'd0;
        m1_mem_addr = 32'h2000_0000; m1_mem_wdata = 32'hA5A5_A5A5; m1_mem_wstrb = 4'b0011;
        s_mem_ready = 1'b1; s_mem_rdata = 32'h1234_5678;
        model_reset();

        // Reset state with live inputs: outputs must all stay zero.
        #12;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_s_valid", {31'd0, s_mem_valid}, 32'd0);
        check("rst_m0_ready", {31'd0, m0_mem_ready}, 32'd0);
        check("rst_m0_rdata", m0_mem_rdata, 32'd0);
        check("rst_s_addr", s_mem_addr, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        m0_mem_valid = 1'b0; m1_mem_valid = 1'b0; m0_mem_instr = 1'b0; m1_mem_instr = 1'b0;
        s_mem_ready = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Read with two wait states, watchdog expiry, recovery, coincident expiry.
        tbl[0]  = mk(1, 0, 0, 0, 32'd0,        2'b00, 0, 8'd0);
        tbl[1]  = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd0);
        tbl[2]  = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd0);
        tbl[3]  = mk(1, 1, 1, 1, 32'h1234_5678, 2'b01, 0, 8'd0);
        tbl[4]  = mk(0, 0, 0, 0, 32'd0,        2'b00, 0, 8'd0);
        tbl[5]  = mk(1, 0, 0, 0, 32'd0,        2'b00, 0, 8'd0);
        tbl[6]  = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd0);
        tbl[7]  = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd0);
        tbl[8]  = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd0);
        tbl[9]  = mk(1, 0, 1, 1, ERR,          2'b01, 1, 8'd0);
        tbl[10] = mk(0, 0, 0, 0, 32'd0,        2'b00, 0, 8'd1);
        tbl[11] = mk(1, 0, 0, 0, 32'd0,        2'b00, 0, 8'd1);
        tbl[12] = mk(1, 1, 1, 1, 32'h1234_5678, 2'b01, 0, 8'd1);
        tbl[13] = mk(0, 0, 0, 0, 32'd0,        2'b00, 0, 8'd1);
        tbl[14] = mk(1, 0, 0, 0, 32'd0,        2'b00, 0, 8'd1);
        tbl[15] = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd1);
        tbl[16] = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd1);
        tbl[17] = mk(1, 0, 1, 0, ERR,          2'b01, 0, 8'd1);
        tbl[18] = mk(1, 1, 1, 1, 32'h1234_5678, 2'b01, 0, 8'd1);
        tbl[19] = mk(0, 0, 0, 0, 32'd0,        2'b00, 0, 8'd1);

        for (int i = 0; i < 20; i++) begin
            m0_mem_valid = tbl[i].m0v;
            s_mem_ready  = tbl[i].srdy;
            @(negedge clk);
            check($sformatf("vec%0d_s_valid", i), {31'd0, s_mem_valid}, {31'd0, tbl[i].e_sval});
            check($sformatf("vec%0d_s_addr", i), s_mem_addr, tbl[i].e_sval ? 32'h100 : 32'd0);
            check($sformatf("vec%0d_m0_ready", i), {31'd0, m0_mem_ready}, {31'd0, tbl[i].e_m0rdy});
            check($sformatf("vec%0d_m0_rdata", i), m0_mem_rdata, tbl[i].e_m0rd);
            check($sformatf("vec%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].e_gnt});
            check($sformatf("vec%0d_timeout", i), {31'd0, timeout_err}, {31'd0, tbl[i].e_to});
            check($sformatf("vec%0d_err_count", i), {24'd0, err_count}, {24'd0, tbl[i].e_err});
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        // Fairness: both held with a zero-wait fabric right after reset.
        do_reset();
        m0_mem_valid = 1'b1; m1_mem_valid = 1'b1; s_mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            #2;
            if (grant != 2'b00) gq.push_back(grant);
        end
        check("rr_count", gq.size(), 32'd6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            check($sformatf("rr_grant%0d", i), {30'd0, gq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);

        // m1 write while m0 is pending: only m1's fields reach the fabric.
        m0_mem_valid = 1'b0; s_mem_ready = 1'b0;
        m0_mem_addr = 32'h0000_0100; m0_mem_wdata = 32'h1111_1111; m0_mem_wstrb = 4'b1111;
        tick();
        m0_mem_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("wr_grant", {30'd0, grant}, 32'd2);
            check("wr_addr", s_mem_addr, 32'h2000_0000);
            check("wr_wdata", s_mem_wdata, 32'hA5A5_A5A5);
            check("wr_wstrb", {28'd0, s_mem_wstrb}, 32'h3);
            tick();
        end
        s_mem_ready = 1'b1;
        #1;
        check("wr_m1_ready", {31'd0, m1_mem_ready}, 32'd1);
        check("wr_m0_ready", {31'd0, m0_mem_ready}, 32'd0);
        tick();
        m1_mem_valid = 1'b0;
        tick();
        #2;
        check("after_wr_m0_addr", s_mem_addr, 32'h0000_0100);
        tick();
        m0_mem_valid = 1'b0;
        tick();

        // Asynchronous reset in the middle of a BUSY1 transfer.
        m1_mem_valid = 1'b1; s_mem_ready = 1'b0;
        tick();
        #2;
        check("pre_rst_s_valid", {31'd0, s_mem_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        check("arst_s_valid", {31'd0, s_mem_valid}, 32'd0);
        check("arst_grant", {30'd0, grant}, 32'd0);
        check("arst_m1_rdata", m1_mem_rdata, 32'd0);
        check("arst_s_addr", s_mem_addr, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        m0_mem_valid = 1'b1;
        tick();
        #2;
        check("arst_first_tie", {30'd0, grant}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            m0_mem_valid = ($urandom_range(3) != 0);
            m1_mem_valid = ($urandom_range(2) == 0);
            m0_mem_instr = $urandom_range(1);
            m1_mem_instr = $urandom_range(1);
            m0_mem_addr  = $urandom; m0_mem_wdata = $urandom; m0_mem_wstrb = 4'($urandom);
            m1_mem_addr  = $urandom; m1_mem_wdata = $urandom; m1_mem_wstrb = 4'($urandom);
            s_mem_ready  = ($urandom_range(3) == 0);
            s_mem_rdata  = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-requester arbiter that shares a single picorv32 native memory port between the CPU (requester 0) and a secondary master such as a DMA engine or debug loader (requester 1). It sits between the core's `mem_*` interface and the memory/peripheral fabric. It grants one transaction at a time with round-robin fairness. A watchdog completes any transfer the fabric never acknowledges, so a hung slave cannot deadlock the core.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles a granted transfer may wait for `s_mem_ready` before forced completion; 0 disables the watchdog.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on a timed-out transfer.
- `clk`  in  1: single clock; all logic is rising-edge.
- `resetn`  in  1: asynchronous active-low reset; deassertion is synchronous to `clk` externally.
- `m0_mem_valid`, `m1_mem_valid`  in  1: request from requester 0 / 1.
- `m0_mem_instr`, `m1_mem_instr`  in  1: instruction-fetch qualifier.
- `m0_mem_addr`, `m1_mem_addr`  in  32: byte address.
- `m0_mem_wdata`, `m1_mem_wdata`  in  32: write data.
- `m0_mem_wstrb`, `m1_mem_wstrb`  in  4: byte write strobes; 0 means read.
- `m0_mem_ready`, `m1_mem_ready`  out  1: one-cycle completion pulse to the requester.
- `m0_mem_rdata`, `m1_mem_rdata`  out  32: read data, valid only while the matching ready is high.
- `s_mem_valid`, `s_mem_instr`, `s_mem_addr`, `s_mem_wdata`, `s_mem_wstrb`  out  1/1/32/32/4: downstream request.
- `s_mem_ready`  in  1: downstream completion.
- `s_mem_rdata`  in  32: downstream read data.
- `grant`  out  2: one-hot owner of the downstream port; 00 when idle.
- `timeout_err`  out  1: one-cycle pulse on a forced completion.
- `err_count`  out  8: saturating count of timeouts.

## Operation
- States: `IDLE`, `BUSY0`, `BUSY1`.
- `IDLE` with exactly one `mX_mem_valid` high: go to `BUSYX` at the next edge.
- `IDLE` with both valid: grant the requester that is not `last`; set `last` to the winner.
- `last` reset value is 1, so requester 0 wins the first tie.
- `BUSYX` drives the downstream port from requester X:
  - `s_mem_valid = mX_mem_valid`;
  - `s_mem_instr`, `s_mem_addr`, `s_mem_wdata`, `s_mem_wstrb` are muxed from requester X;
  - all downstream outputs are 0 in `IDLE`.
- `mX_mem_ready = BUSYX && mX_mem_valid && (s_mem_ready || wd_expire)`.
- `mX_mem_rdata = s_mem_ready ? s_mem_rdata : ERR_RDATA` when X is granted; 0 otherwise.
- Non-granted requester: ready is 0 and its valid is ignored.
- `BUSYX` returns to `IDLE` at the edge after the ready pulse.
- `BUSYX` with `mX_mem_valid` low (protocol abort): return to `IDLE` at the next edge; no ready pulse; downstream valid drops the same cycle.
- Watchdog:
  - the counter clears on entry to `BUSYX` and increments each `BUSYX` cycle while `s_mem_ready` is low;
  - `wd_expire` is high when the counter equals `TIMEOUT_CYCLES - 1` and `TIMEOUT_CYCLES != 0`;
  - counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
- On expiry: ready pulse to the owner with `ERR_RDATA`, `timeout_err` = 1 for that cycle, `err_count` += 1 saturating at 255; `s_mem_valid` drops at the next edge.
- `s_mem_ready` and `wd_expire` in the same cycle: this is a normal completion; real `s_mem_rdata` is returned and there is no error.
- `s_mem_ready` while `IDLE`: ignored.
- Reset, asynchronous, at any time including mid-transfer:
  - state `IDLE`, `last` = 1, watchdog 0, `err_count` 0;
  - all outputs 0, `grant` 00.

## Timing
- Request-to-downstream latency: requester valid at cycle t gives `s_mem_valid` at t+1.
- Zero-wait fabric: ready at t+1 back to the requester.
- Ready and rdata are combinational from the fabric in the granted state.
- Minimum one `IDLE` bubble between transactions; sustained single-requester throughput is one transfer per 2 cycles plus fabric wait.
- Registered elements: `grant`/state, `last`, watchdog, `err_count`.
- `timeout_err` and all `mem_ready` outputs are combinational pulses of exactly one cycle.

## Test plan
- Reset, then m0 reads 0x100 with fabric ready after 2 wait cycles and rdata 0x1234_5678:
  - `s_mem_valid` rises at t+1;
  - `m0_mem_ready` pulses at t+3 with 0x1234_5678;
  - `grant` is 01 and then 00.
- Both requesters valid at the same edge after reset, zero-wait fabric:
  - m0 is served first, then m1;
  - with both held continuously, grants alternate 01, 10, 01 for 3 transactions each;
  - no requester ever waits more than one transaction.
- m1 write, addr 0x2000_0000, wdata 0xA5A5_A5A5, wstrb 4'b0011, while m0 is pending:
  - downstream sees m1's exact address, data and strobes;
  - m0's fields are never visible on `s_mem_*` during `BUSY1`.
- `TIMEOUT_CYCLES`=4, fabric never ready:
  - requester ready pulses 4 cycles after grant with 0xDEAD_BEEF;
  - `timeout_err` pulses once and `err_count` = 1;
  - the next request is served normally.
- `s_mem_ready` coincident with watchdog expiry: real rdata is returned, `timeout_err` stays 0, `err_count` is unchanged.
- `resetn` asserted mid-`BUSY1` with `s_mem_valid` high: all outputs are 0 immediately, without waiting for a clock edge; after release, a simultaneous request goes to m0 first.
